// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART receiver.
package uart_pkg;

  // Parity mode of a frame.
  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  // Receiver frame states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line conditioning for uart_rx: 2-flop synchroniser plus, when
// UART_RX_MAJORITY_EN is defined, a 3-tap majority filter on the
// synchronised line. sample_c is what the frame FSM samples.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic uart_rx,
  output logic rx_s,
  output logic sample_c
);

  logic rx_meta;

  // Two-stage synchroniser; idles high out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // Two older copies of rx_s; the vote window is centred one clock back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample_c = maj3(rx_s, hist[0], hist[1]);
`else
  assign sample_c = rx_s;
`endif

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: configurable data width, parity and stop
// bits, with parity and framing error reporting. One ok pulse per frame.
// Optional feature: define UART_RX_MAJORITY_EN to take every mid-bit sample
// as a 2-of-3 majority around the sample point (one extra clock of latency).
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 4,
  parameter int unsigned CLK_PER_BIT      = 8,
  parameter int unsigned DATA_BITS        = 8,
  parameter parity_e     PARITY           = PAR_NONE,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 ok,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 waiting
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_PER_HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY == PAR_ODD);

  // Parameter range checks at elaboration.
  if (CLK_PER_BIT < 4) begin : g_chk_cpb
    $error("uart_rx_framed: CLK_PER_BIT must be >= 4");
  end
  if (CLK_PER_HALF_BIT < 2 || CLK_PER_HALF_BIT > CLK_PER_BIT - 1) begin : g_chk_half
    $error("uart_rx_framed: CLK_PER_HALF_BIT must be in 2..CLK_PER_BIT-1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_rx_framed: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_rx_framed: STOP_BITS must be 1 or 2");
  end

  logic                 rx_s;
  logic                 line;
  rx_state_e            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 pe_pend;
  logic                 fe_acc;
  logic                 armed;
  logic                 mid;

  uart_rx_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_s     (rx_s),
    .sample_c (line)
  );

  assign mid = (cnt == CNT_MID);

  // Frame FSM: start qualification, mid-bit sampling and result registers.
  // armed blocks a new start until the line has been seen high, so a break
  // following a bad stop bit is not taken as a fresh frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      pe_pend    <= 1'b0;
      fe_acc     <= 1'b0;
      armed      <= 1'b1;
      data       <= '0;
      ok         <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      waiting    <= 1'b1;
    end else begin
      ok <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end
          if (!line && armed) begin
            state   <= ST_START;
            cnt     <= CNT_ONE;
            waiting <= 1'b0;
          end
        end

        ST_START: begin
          if (cnt == CNT_HALF) begin
            if (line) begin
              state   <= ST_IDLE;
              waiting <= 1'b1;
            end else begin
              state   <= ST_DATA;
              cnt     <= '0;
              idx     <= '0;
              par_acc <= 1'b0;
              pe_pend <= 1'b0;
              fe_acc  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (mid) begin
            cnt     <= '0;
            shreg   <= {line, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ line;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_PARITY: begin
          if (mid) begin
            cnt     <= '0;
            pe_pend <= ((par_acc ^ line) != ODD_PAR);
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_STOP: begin
          if (mid) begin
            cnt <= '0;
            if (idx == STOP_LAST) begin
              ok         <= 1'b1;
              data       <= shreg;
              parity_err <= pe_pend;
              frame_err  <= fe_acc | ~line;
              armed      <= line;
              idx        <= '0;
              state      <= ST_IDLE;
              waiting    <= 1'b1;
            end else begin
              fe_acc <= fe_acc | ~line;
              idx    <= idx + IDX_ONE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state   <= ST_IDLE;
          waiting <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: three instances (8N1, 8E1, 8N2), each on its
// own serial line, driven with directed frames and checked against
// hand-computed expectations.
module tb_uart_rx_framed;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] line;
  logic [7:0] data0, data1, data2;
  logic [2:0] ok_w, pe_w, fe_w, wait_w;

  always #5 clk = ~clk;

  uart_rx_framed #(.PARITY(PAR_NONE), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .uart_rx(line[0]), .data(data0),
    .ok(ok_w[0]), .parity_err(pe_w[0]), .frame_err(fe_w[0]), .waiting(wait_w[0]));

  uart_rx_framed #(.PARITY(PAR_EVEN), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .uart_rx(line[1]), .data(data1),
    .ok(ok_w[1]), .parity_err(pe_w[1]), .frame_err(fe_w[1]), .waiting(wait_w[1]));

  uart_rx_framed #(.PARITY(PAR_NONE), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .uart_rx(line[2]), .data(data2),
    .ok(ok_w[2]), .parity_err(pe_w[2]), .frame_err(fe_w[2]), .waiting(wait_w[2]));

  typedef struct {
    int         dut;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       w;
  } rec_t;

  typedef struct {
    int         dut;
    logic [7:0] payload;
    int         par;     // -1: no parity bit, else the parity bit value sent
    logic [1:0] stops;   // bit0 = first stop bit, bit1 = second
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  rec_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Record every ok pulse of every instance in arrival order.
  always @(negedge clk) begin
    if (ok_w[0]) q.push_back('{0, data0, pe_w[0], fe_w[0], wait_w[0]});
    if (ok_w[1]) q.push_back('{1, data1, pe_w[1], fe_w[1], wait_w[1]});
    if (ok_w[2]) q.push_back('{2, data2, pe_w[2], fe_w[2], wait_w[2]});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dout(input int d);
    case (d)
      0:       return data0;
      1:       return data1;
      default: return data2;
    endcase
  endfunction

  task automatic get_rec(output rec_t r);
    if (q.size() > 0) r = q.pop_front();
    else r = '{-1, 8'h00, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic drive_bit(input int d, input logic v, input bit g);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      line[d] = (g && c == 4) ? ~v : v;
    end
  endtask

  task automatic send(input int d, input logic [7:0] p, input int par,
                      input logic [1:0] stops, input int nstop, input bit g);
    drive_bit(d, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d, p[i], g);
    if (par >= 0) drive_bit(d, par[0], 1'b0);
    for (int s = 0; s < nstop; s++) drive_bit(d, stops[s], 1'b0);
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(negedge clk);
      line[d] = 1'b1;
    end
  endtask

  vec_t vecs[10];
  rec_t r;
  int   t_lo, t_hi;
  bit   saw_low, wait_ok;

  initial begin
    vecs[0] = '{0, 8'h3A, -1, 2'b11, 8'h3A, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h55, -1, 2'b10, 8'h55, 1'b0, 1'b1};
    vecs[2] = '{1, 8'h87,  1, 2'b11, 8'h87, 1'b1, 1'b0};
    vecs[3] = '{1, 8'h87,  0, 2'b11, 8'h87, 1'b0, 1'b0};
    vecs[4] = '{1, 8'h01,  1, 2'b11, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{1, 8'h01,  0, 2'b11, 8'h01, 1'b1, 1'b0};
    vecs[6] = '{2, 8'h3C, -1, 2'b11, 8'h3C, 1'b0, 1'b0};
    vecs[7] = '{2, 8'hF0, -1, 2'b01, 8'hF0, 1'b0, 1'b1};
    vecs[8] = '{2, 8'h0F, -1, 2'b10, 8'h0F, 1'b0, 1'b1};
    vecs[9] = '{0, 8'hFF, -1, 2'b11, 8'hFF, 1'b0, 1'b0};

    // Reset values.
    reset = 1'b0;
    line  = 3'b111;
    repeat (2) @(negedge clk);
    chk("rst_data", data0, 8'h00);
    chk("rst_ok", ok_w, 3'b000);
    chk("rst_pe", pe_w, 3'b000);
    chk("rst_fe", fe_w, 3'b000);
    chk("rst_waiting", wait_w, 3'b111);
    reset = 1'b1;
    idle(0, 5);

    // Table of single frames.
    for (int v = 0; v < 10; v++) begin
      q.delete();
      send(vecs[v].dut, vecs[v].payload, vecs[v].par, vecs[v].stops,
           (vecs[v].dut == 2) ? 2 : 1, 1'b0);
      idle(vecs[v].dut, 24);
      chk($sformatf("v%0d_count", v), q.size(), 1);
      get_rec(r);
      chk($sformatf("v%0d_dut", v), r.dut, vecs[v].dut);
      chk($sformatf("v%0d_data", v), r.d, vecs[v].exp_d);
      chk($sformatf("v%0d_pe", v), r.pe, vecs[v].exp_pe);
      chk($sformatf("v%0d_fe", v), r.fe, vecs[v].exp_fe);
      chk($sformatf("v%0d_hold", v), dout(vecs[v].dut), vecs[v].exp_d);
      chk($sformatf("v%0d_ok_low", v), ok_w, 3'b000);
    end

    // Back-to-back 8N1 frames.
    q.delete();
    send(0, 8'hCD, -1, 2'b11, 1, 1'b0);
    send(0, 8'h87, -1, 2'b11, 1, 1'b0);
    idle(0, 24);
    chk("b2b_count", q.size(), 2);
    get_rec(r);
    chk("b2b0_data", r.d, 8'hCD);
    chk("b2b0_err", {r.pe, r.fe}, 2'b00);
    chk("b2b0_waiting", r.w, 1'b1);
    get_rec(r);
    chk("b2b1_data", r.d, 8'h87);
    chk("b2b1_err", {r.pe, r.fe}, 2'b00);
    chk("b2b1_waiting", r.w, 1'b1);

    // One-clock low glitch on an idle line.
    q.delete();
    @(negedge clk);
    line[0] = 1'b0;
    saw_low = 1'b0;
    t_lo = -1;
    t_hi = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      line[0] = 1'b1;
      if (!wait_w[0] && !saw_low) begin
        saw_low = 1'b1;
        t_lo = i;
      end
      if (wait_w[0] && saw_low && t_hi < 0) t_hi = i;
    end
`ifdef UART_RX_MAJORITY_EN
    chk("glitch_start_seen", saw_low, 1'b0);
`else
    chk("glitch_start_seen", saw_low, 1'b1);
    chk("glitch_recover", (t_hi >= 0) && (t_hi - t_lo <= 7), 1'b1);
`endif
    idle(0, 10);
    chk("glitch_no_ok", q.size(), 0);
    chk("glitch_waiting", wait_w[0], 1'b1);

    // 8N2 with low second stop bit, then the line held low (break).
    q.delete();
    send(2, 8'hA3, -1, 2'b01, 2, 1'b0);
    wait_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      line[2] = 1'b0;
      if (i >= 3 && !wait_w[2]) wait_ok = 1'b0;
    end
    chk("break_count", q.size(), 1);
    chk("break_no_restart", wait_ok, 1'b1);
    idle(2, 24);
    chk("break_count_after", q.size(), 1);
    get_rec(r);
    chk("break_data", r.d, 8'hA3);
    chk("break_fe", r.fe, 1'b1);
    chk("break_pe", r.pe, 1'b0);
    send(2, 8'h5A, -1, 2'b11, 2, 1'b0);
    idle(2, 24);
    chk("post_break_count", q.size(), 1);
    get_rec(r);
    chk("post_break_data", r.d, 8'h5A);
    chk("post_break_fe", r.fe, 1'b0);

    // Reset pulse in the middle of the data bits.
    q.delete();
    drive_bit(0, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    drive_bit(0, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    @(negedge clk);
    line[0] = 1'b1;
    reset = 1'b0;
    #1;
    chk("midrst_data", data0, 8'h00);
    chk("midrst_data2", data2, 8'h00);
    chk("midrst_ok", ok_w[0], 1'b0);
    chk("midrst_err", {pe_w[0], fe_w[0]}, 2'b00);
    chk("midrst_waiting", wait_w[0], 1'b1);
    @(negedge clk);
    reset = 1'b1;
    idle(0, 90);
    chk("midrst_no_ok", q.size(), 0);
    send(0, 8'h55, -1, 2'b11, 1, 1'b0);
    idle(0, 24);
    chk("after_rst_count", q.size(), 1);
    get_rec(r);
    chk("after_rst_data", r.d, 8'h55);
    chk("after_rst_err", {r.pe, r.fe}, 2'b00);

    // Inverted one-clock glitch at every data mid-bit of 0xA5.
    q.delete();
    send(0, 8'hA5, -1, 2'b11, 1, 1'b1);
    idle(0, 24);
    chk("maj_count", q.size(), 1);
    get_rec(r);
`ifdef UART_RX_MAJORITY_EN
    chk("maj_data", r.d, 8'hA5);
`else
    chk("maj_data", r.d, 8'h5A);
`endif
    chk("maj_fe", r.fe, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
